// File: rtl/huffman_pkg.sv
// Shared types and default sizing for the Huffman bit packer.
package huffman_pkg;

    localparam int DEF_CODE_W = 8;
    localparam int DEF_LEN_W  = 4;
    localparam int DEF_OUT_W  = 32;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        FLUSH_EMIT
    } state_t;

endpackage

// File: rtl/huffman_out_reg.sv
// Output holding register: keeps a packed word, its bit count and last flag until taken.
module huffman_out_reg #(
    parameter int OUT_W  = 32,
    parameter int BITS_W = $clog2(OUT_W + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [OUT_W-1:0]  load_data,
    input  logic [BITS_W-1:0] load_bits,
    input  logic              load_last,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  encoded_out,
    output logic              enable_out,
    output logic [BITS_W-1:0] out_bits,
    output logic              out_last,
    output logic              out_free
);

    // Room for a new word when empty or when the held word leaves on this edge.
    assign out_free = !enable_out || out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            encoded_out <= '0;
            enable_out  <= 1'b0;
            out_bits    <= '0;
            out_last    <= 1'b0;
        end else if (load) begin
            encoded_out <= load_data;
            enable_out  <= 1'b1;
            out_bits    <= load_bits;
            out_last    <= load_last;
        end else if (out_ready) begin
            enable_out  <= 1'b0;
        end
    end

endmodule

// File: rtl/huffman_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words, with a flush that
// emits the trailing partial word left-aligned and zero-padded.
module huffman_packer
    import huffman_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int OUT_W  = DEF_OUT_W
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [CODE_W-1:0]          code,
    input  logic [LEN_W-1:0]           length,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [OUT_W-1:0]           encoded_out,
    output logic                       enable_out,
    input  logic                       out_ready,
    output logic [$clog2(OUT_W+1)-1:0] out_bits,
    output logic                       out_last,
    output logic                       len_err
);

    localparam int ACC_W  = OUT_W + CODE_W;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam int BITS_W = $clog2(OUT_W + 1);

    state_t             state;
    logic [FILL_W-1:0]  fill;
    logic [ACC_W-1:0]   acc;

    logic               accept;
    logic               over_len;
    logic [LEN_W-1:0]   eff_len;
    logic [CODE_W-1:0]  masked_code;
    logic [FILL_W-1:0]  shift_amt;
    logic [ACC_W-1:0]   append_vec;
    logic               out_free;
    logic               full_load;
    logic               res_load;
    logic               load;
    logic [BITS_W-1:0]  load_bits;

    assign in_ready = (state == RUN) && (fill < FILL_W'(OUT_W));
    assign accept   = in_valid && in_ready;

    // The accumulator is left-aligned: valid bits occupy the top `fill` positions,
    // everything below is kept zero so the residue is already zero-padded.
    always_comb begin
        over_len    = length > LEN_W'(CODE_W);
        eff_len     = over_len ? LEN_W'(CODE_W) : length;
        masked_code = code & ~({CODE_W{1'b1}} << eff_len);
        shift_amt   = FILL_W'(ACC_W) - fill - FILL_W'(eff_len);
        append_vec  = ACC_W'(masked_code) << shift_amt;
    end

    assign full_load = (state != FLUSH_EMIT) && (fill >= FILL_W'(OUT_W)) && out_free;
    assign res_load  = (state == FLUSH_EMIT) && (fill != '0) && out_free;
    assign load      = full_load || res_load;
    assign load_bits = full_load ? BITS_W'(OUT_W) : BITS_W'(fill);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= RUN;
            fill    <= '0;
            acc     <= '0;
            len_err <= 1'b0;
        end else begin
            // Accept and word extraction never coincide: in_ready is low once fill reaches OUT_W.
            if (accept) begin
                acc  <= acc | append_vec;
                fill <= fill + FILL_W'(eff_len);
                if (over_len) begin
                    len_err <= 1'b1;
                end
            end else if (full_load) begin
                acc  <= acc << OUT_W;
                fill <= fill - FILL_W'(OUT_W);
            end else if (res_load) begin
                acc  <= '0;
                fill <= '0;
            end

            case (state)
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fill < FILL_W'(OUT_W)) begin
                        state <= (fill != '0) ? FLUSH_EMIT : RUN;
                    end
                end
                FLUSH_EMIT: begin
                    // fill is nonzero on entry, so fill==0 here means the residue is in the output register.
                    if ((fill == '0) && enable_out && out_ready) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    huffman_out_reg #(
        .OUT_W  (OUT_W),
        .BITS_W (BITS_W)
    ) u_out_reg (
        .clock       (clock),
        .resetn      (resetn),
        .load        (load),
        .load_data   (acc[ACC_W-1 -: OUT_W]),
        .load_bits   (load_bits),
        .load_last   (res_load),
        .out_ready   (out_ready),
        .encoded_out (encoded_out),
        .enable_out  (enable_out),
        .out_bits    (out_bits),
        .out_last    (out_last),
        .out_free    (out_free)
    );

endmodule
